// File: rtl/r16_input_gather_pkg.sv
// Shared constants and helpers for the R16 input gather block.
// Optional build macro used by this slice: R16_GATHER_BITREV_EN.
package r16_input_gather_pkg;
  localparam int D_WIDTH_DEF = 64;
  localparam int LANES       = 16;
  localparam int GIDX_W      = 12;
  localparam int LCNT_W      = 4;

  function automatic logic [LCNT_W-1:0] bitrev4(input logic [LCNT_W-1:0] c);
    return {c[0], c[1], c[2], c[3]};
  endfunction
endpackage

// File: rtl/r16_input_gather_if.sv
// Serial-in / group-out stream bundle for the R16 input gather.
// slave = the gather block, master = its producer/consumer side.
interface r16_input_gather_if
  import r16_input_gather_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
);
  logic                       in_valid;
  logic                       in_ready;
  logic [D_WIDTH-1:0]         in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*D_WIDTH-1:0]   out_data;
  logic [GIDX_W-1:0]          out_gidx;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_gidx
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_gidx
  );
endinterface

// File: rtl/r16_gather_bank.sv
// One LANES x D_WIDTH register bank: single-lane write port, full-width read,
// cleared by the asynchronous reset.
module r16_gather_bank
  import r16_input_gather_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [LCNT_W-1:0]        i_lane,
  input  logic [D_WIDTH-1:0]       i_data,
  output logic [LANES*D_WIDTH-1:0] o_data
);
  logic [LANES-1:0][D_WIDTH-1:0] r_lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
    end else if (i_we) begin
      for (int k = 0; k < LANES; k++)
        if (i_lane == LCNT_W'(k)) r_lane[k] <= i_data;
    end
  end

  assign o_data = r_lane;
endmodule

// File: rtl/r16_input_gather.sv
// Serial-to-parallel loader ahead of the radix-16 input delay stage.
// Ping-pong banks; R16_GATHER_BITREV_EN selects digit-reversed lane packing.
module r16_input_gather
  import r16_input_gather_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  r16_input_gather_if.slave  g_if
);
  logic [1:0]              r_full;
  logic                    r_wptr;
  logic                    r_rptr;
  logic [LCNT_W-1:0]       r_lcnt;
  logic [GIDX_W-1:0]       r_gidx;

  logic                    w_accept;
  logic                    w_drain;
  logic                    w_fill_done;
  logic [LCNT_W-1:0]       w_lane;
  logic [1:0]              w_we;
  logic [1:0]              w_set;
  logic [1:0]              w_clr;
  logic [LANES*D_WIDTH-1:0] w_bank_q [2];

`ifdef R16_GATHER_BITREV_EN
  assign w_lane = bitrev4(r_lcnt);
`else
  assign w_lane = r_lcnt;
`endif

  // in_ready depends on registers only, so out_ready never reaches it.
  assign g_if.in_ready = !r_full[r_wptr];
  assign w_accept      = g_if.in_valid && !r_full[r_wptr];
  assign w_fill_done   = w_accept && (r_lcnt == {LCNT_W{1'b1}});
  assign w_drain       = r_full[r_rptr] && g_if.out_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_we[b]  = w_accept    && (r_wptr == 1'(b));
    assign w_set[b] = w_fill_done && (r_wptr == 1'(b));
    assign w_clr[b] = w_drain     && (r_rptr == 1'(b));

    r16_gather_bank #(.D_WIDTH(D_WIDTH)) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_we   (w_we[b]),
      .i_lane (w_lane),
      .i_data (g_if.in_data),
      .o_data (w_bank_q[b])
    );
  end

  // A bank being filled is never full, so set and clear never hit the same bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_lcnt <= '0;
      r_gidx <= '0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_accept)    r_lcnt <= r_lcnt + LCNT_W'(1);
      if (w_fill_done) r_wptr <= ~r_wptr;
      if (w_drain) begin
        r_rptr <= ~r_rptr;
        r_gidx <= r_gidx + GIDX_W'(1);
      end
    end
  end

  assign g_if.out_valid = r_full[r_rptr];
  assign g_if.out_data  = w_bank_q[r_rptr];
  assign g_if.out_gidx  = r_gidx;
endmodule
